// File: rtl/mc_stage_regbank_pkg.sv
// Shared definitions for the inter-stage register bank: default sizes,
// the per-edge operation decode and the occupancy counter width helper.
package mc_stage_regbank_pkg;

   localparam int DEFAULT_WIDTH    = 32;
   localparam int DEFAULT_CHANNELS = 4;
   localparam int DEFAULT_DEPTH    = 1;

   // What the whole bank does on a given rising edge, highest priority first.
   typedef enum logic [1:0] {
      OP_RESET = 2'd0,
      OP_FLUSH = 2'd1,
      OP_STALL = 2'd2,
      OP_SHIFT = 2'd3
   } regbank_op_e;

   // Occupancy must count 0..depth inclusive and never shrink below one bit.
   function automatic int occ_width(input int depth);
      if (depth < 2) begin
         return 1;
      end
      return $clog2(depth + 1);
   endfunction

   // Resolve the control inputs into the single operation applied this edge.
   function automatic regbank_op_e decode_op(input logic rst,
                                             input logic flush,
                                             input logic stall);
      if (rst) begin
         return OP_RESET;
      end
      if (flush) begin
         return OP_FLUSH;
      end
      if (stall) begin
         return OP_STALL;
      end
      return OP_SHIFT;
   endfunction

endpackage

// File: rtl/mc_stage_regbank_if.sv
// Controller-facing bus of the register bank: pipeline controls, stage-0
// write data and the last-stage outputs plus occupancy.
interface mc_stage_regbank_if
   import mc_stage_regbank_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int CHANNELS = DEFAULT_CHANNELS,
   parameter int DEPTH    = DEFAULT_DEPTH
);

   localparam int OCC_W  = occ_width(DEPTH);
   localparam int DATA_W = CHANNELS * WIDTH;

   logic                stall;
   logic                flush;
   logic                in_valid;
   logic [CHANNELS-1:0] we;
   logic [DATA_W-1:0]   din;
   logic [DATA_W-1:0]   dout;
   logic                out_valid;
   logic [OCC_W-1:0]    occ;

   // The controller drives the pipeline and observes the last stage.
   modport master (
      output stall,
      output flush,
      output in_valid,
      output we,
      output din,
      input  dout,
      input  out_valid,
      input  occ
   );

   // The register bank consumes the controls and presents its last stage.
   modport slave (
      input  stall,
      input  flush,
      input  in_valid,
      input  we,
      input  din,
      output dout,
      output out_valid,
      output occ
   );

endinterface

// File: rtl/mc_regbank_stage.sv
// One pipeline stage of the register bank: CHANNELS words of WIDTH bits plus
// a valid bit. Each channel loads independently; the valid bit can be loaded
// or cleared without touching the data words.
module mc_regbank_stage
   import mc_stage_regbank_pkg::*;
#(
   parameter int                WIDTH    = DEFAULT_WIDTH,
   parameter int                CHANNELS = DEFAULT_CHANNELS,
   parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS-1:0]          load_data,
   input  logic                         load_valid,
   input  logic                         clr_valid,
   input  logic [CHANNELS*WIDTH-1:0]    data_in,
   input  logic                         valid_in,
   output logic [CHANNELS*WIDTH-1:0]    data_out,
   output logic                         valid_out
);

   // Reset loads RST_VAL everywhere; otherwise clear beats the valid load and data follows per-channel enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out  <= {CHANNELS{RST_VAL}};
         valid_out <= 1'b0;
      end else begin
         if (clr_valid) begin
            valid_out <= 1'b0;
         end else if (load_valid) begin
            valid_out <= valid_in;
         end
         for (int c = 0; c < CHANNELS; c++) begin
            if (load_data[c]) begin
               data_out[c*WIDTH +: WIDTH] <= data_in[c*WIDTH +: WIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/mc_stage_regbank.sv
// Inter-stage register bank for the multicycle datapath (IR/DR/A/B/ALUOut).
// DEPTH stages of CHANNELS words shift forward each edge unless stalled,
// flushed or reset. Stage 0 merges new words per channel under we, so a
// channel without its enable keeps its own previous value. Outputs come
// straight from the last stage registers and the occupancy register.
module mc_stage_regbank
   import mc_stage_regbank_pkg::*;
#(
   parameter int                WIDTH    = DEFAULT_WIDTH,
   parameter int                CHANNELS = DEFAULT_CHANNELS,
   parameter int                DEPTH    = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
   input  logic               clk,
   input  logic               rst,
   mc_stage_regbank_if.slave  bus
);

   localparam int DATA_W = CHANNELS * WIDTH;
   localparam int OCC_W  = occ_width(DEPTH);

   // A zero-depth bank has no latency register at all and cannot be built.
   if (DEPTH < 1) begin : g_bad_depth
      $error("mc_stage_regbank: DEPTH must be at least 1");
   end
   if (WIDTH < 1 || CHANNELS < 1) begin : g_bad_size
      $error("mc_stage_regbank: WIDTH and CHANNELS must be at least 1");
   end

   regbank_op_e         op;
   logic                shift_en;
   logic                flush_en;

   logic [DATA_W-1:0]   stage_data  [DEPTH];
   logic                stage_valid [DEPTH];
   logic [DATA_W-1:0]   stage_din   [DEPTH];
   logic                stage_vin   [DEPTH];
   logic [CHANNELS-1:0] stage_ld    [DEPTH];

   logic [DEPTH-1:0]    valid_next;
   logic [OCC_W-1:0]    occ_next;
   logic [OCC_W-1:0]    occ_q;

   assign op       = decode_op(rst, bus.flush, bus.stall);
   assign shift_en = (op == OP_SHIFT);
   assign flush_en = (op == OP_FLUSH);

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign stage_ld[k]  = shift_en ? bus.we : '0;
         assign stage_din[k] = bus.din;
         assign stage_vin[k] = bus.in_valid;
      end else begin : g_body
         assign stage_ld[k]  = {CHANNELS{shift_en}};
         assign stage_din[k] = stage_data[k-1];
         assign stage_vin[k] = stage_valid[k-1];
      end

      mc_regbank_stage #(
         .WIDTH    (WIDTH),
         .CHANNELS (CHANNELS),
         .RST_VAL  (RST_VAL)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .load_data  (stage_ld[k]),
         .load_valid (shift_en),
         .clr_valid  (flush_en),
         .data_in    (stage_din[k]),
         .valid_in   (stage_vin[k]),
         .data_out   (stage_data[k]),
         .valid_out  (stage_valid[k])
      );
   end

   // Predict the valid bits the stages will hold after this edge and count them.
   always_comb begin
      valid_next = '0;
      occ_next   = '0;
      case (op)
         OP_STALL: begin
            for (int k = 0; k < DEPTH; k++) begin
               valid_next[k] = stage_valid[k];
            end
         end
         OP_SHIFT: begin
            valid_next[0] = bus.in_valid;
            for (int k = 1; k < DEPTH; k++) begin
               valid_next[k] = stage_valid[k-1];
            end
         end
         default: begin
            valid_next = '0;
         end
      endcase
      for (int k = 0; k < DEPTH; k++) begin
         occ_next = occ_next + OCC_W'(valid_next[k]);
      end
   end

   // Occupancy is registered alongside the valid bits so both change on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_next;
      end
   end

   assign bus.dout      = stage_data[DEPTH-1];
   assign bus.out_valid = stage_valid[DEPTH-1];
   assign bus.occ       = occ_q;

endmodule
